// File: rtl/vga_timing_counter.sv
// vga_timing_counter: programmable single-axis VGA timing generator.
// Walks ACTIVE -> FRONT -> SYNC -> BACK and emits position, active,
// sync and carry. New timing is staged in a pending register and only
// takes effect at the wrap, so a line/frame is never torn.
// Optional build macro: VGA_TIMING_POLARITY_EN adds a programmable sync
// polarity input (Cfg_sync_pol); without it Sync is fixed active-low.
module vga_timing_counter #(
    parameter int CNT_WIDTH   = 12,
    parameter int DEF_VISIBLE = 640,
    parameter int DEF_FRONT   = 16,
    parameter int DEF_SYNC    = 96,
    parameter int DEF_BACK    = 48
) (
    input  logic                 Clk,
    input  logic                 Rst,
    input  logic                 En,
    input  logic                 Cfg_valid,
    input  logic [CNT_WIDTH-1:0] Cfg_visible,
    input  logic [CNT_WIDTH-1:0] Cfg_front,
    input  logic [CNT_WIDTH-1:0] Cfg_sync,
    input  logic [CNT_WIDTH-1:0] Cfg_back,
`ifdef VGA_TIMING_POLARITY_EN
    input  logic                 Cfg_sync_pol,
`endif
    output logic                 Cfg_pending,
    output logic                 Cfg_err,
    output logic [CNT_WIDTH-1:0] Count,
    output logic [1:0]           Phase,
    output logic                 Active,
    output logic                 Sync,
    output logic                 Carry
);

    // Sums are kept two bits wider so four max-length fields never overflow.
    localparam int TW = CNT_WIDTH + 2;

    typedef enum logic [1:0] {PH_ACTIVE, PH_FRONT, PH_SYNC, PH_BACK} phase_t;

    typedef struct packed {
        logic                 pol;   // 1 = active-high sync
        logic [CNT_WIDTH-1:0] vis;
        logic [CNT_WIDTH-1:0] front;
        logic [CNT_WIDTH-1:0] sync;
        logic [CNT_WIDTH-1:0] back;
    } timing_t;

    localparam timing_t DEF_TIMING = '{
        pol:   1'b0,
        vis:   CNT_WIDTH'(DEF_VISIBLE),
        front: CNT_WIDTH'(DEF_FRONT),
        sync:  CNT_WIDTH'(DEF_SYNC),
        back:  CNT_WIDTH'(DEF_BACK)
    };

    // Largest legal total is exactly 2^CNT_WIDTH (Count tops out at all-ones).
    localparam logic [TW-1:0] MAX_TOTAL = {2'b01, {CNT_WIDTH{1'b0}}};

    timing_t              live_q, pend_q, cfg_in;
    logic                 pend_vld_q, err_q;
    logic [CNT_WIDTH-1:0] count_q;
    phase_t               phase_q, phase_d;

    logic [TW-1:0] end_act, end_front, end_sync, total, cfg_total, count_inc;
    logic          last, wrap, cfg_bad;

    assign cfg_in.vis   = Cfg_visible;
    assign cfg_in.front = Cfg_front;
    assign cfg_in.sync  = Cfg_sync;
    assign cfg_in.back  = Cfg_back;
`ifdef VGA_TIMING_POLARITY_EN
    assign cfg_in.pol   = Cfg_sync_pol;
`else
    assign cfg_in.pol   = 1'b0;
`endif

    // Phase boundaries of the live timing, as exclusive end positions.
    assign end_act   = TW'(live_q.vis);
    assign end_front = end_act   + TW'(live_q.front);
    assign end_sync  = end_front + TW'(live_q.sync);
    assign total     = end_sync  + TW'(live_q.back);
    assign count_inc = TW'(count_q) + TW'(1);
    assign last      = (count_inc == total);
    assign wrap      = En & last;

    assign cfg_total = TW'(Cfg_visible) + TW'(Cfg_front) + TW'(Cfg_sync) + TW'(Cfg_back);
    assign cfg_bad   = (Cfg_visible == '0) || (Cfg_sync == '0) || (cfg_total > MAX_TOTAL);

    // Next phase: step at each boundary; zero-length FRONT is skipped here and
    // zero-length BACK falls out of the wrap taking priority.
    always_comb begin
        phase_d = phase_q;
        if (last) begin
            phase_d = PH_ACTIVE;
        end else begin
            case (phase_q)
                PH_ACTIVE: if (count_inc == end_act)
                               phase_d = (live_q.front == '0) ? PH_SYNC : PH_FRONT;
                PH_FRONT:  if (count_inc == end_front) phase_d = PH_SYNC;
                PH_SYNC:   if (count_inc == end_sync)  phase_d = PH_BACK;
                default:   phase_d = phase_q;
            endcase
        end
    end

    // Position/phase register, live timing load at wrap, config staging.
    always_ff @(posedge Clk) begin
        if (Rst) begin
            count_q    <= '0;
            phase_q    <= PH_ACTIVE;
            live_q     <= DEF_TIMING;
            pend_q     <= DEF_TIMING;
            pend_vld_q <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            err_q <= Cfg_valid & cfg_bad;
            if (En) begin
                count_q <= last ? '0 : count_inc[CNT_WIDTH-1:0];
                phase_q <= phase_d;
            end
            // Wrap consumes the previously pending value; a same-edge
            // strobe becomes the new pending value.
            if (wrap && pend_vld_q)
                live_q <= pend_q;
            if (Cfg_valid && !cfg_bad) begin
                pend_q     <= cfg_in;
                pend_vld_q <= 1'b1;
            end else if (wrap) begin
                pend_vld_q <= 1'b0;
            end
        end
    end

    assign Count       = count_q;
    assign Phase       = phase_q;
    assign Active      = (phase_q == PH_ACTIVE);
    assign Sync        = (phase_q == PH_SYNC) ? live_q.pol : ~live_q.pol;
    assign Carry       = wrap;
    assign Cfg_pending = pend_vld_q;
    assign Cfg_err     = err_q;

endmodule

// File: tb/tb_vga_timing_counter.sv
// tb_vga_timing_counter: directed plus randomized stimulus against a
// behavioural model that derives phase from position ranges.
module tb_vga_timing_counter;

    localparam int W = 12;

    logic         Clk = 1'b0;
    logic         Rst, En, Cfg_valid, Cfg_sync_pol;
    logic [W-1:0] Cfg_visible, Cfg_front, Cfg_sync, Cfg_back;
    logic         Cfg_pending, Cfg_err, Active, Sync, Carry;
    logic [W-1:0] Count;
    logic [1:0]   Phase;

    always #5 Clk = ~Clk;

    vga_timing_counter #(.CNT_WIDTH(W)) dut (
        .Clk(Clk), .Rst(Rst), .En(En), .Cfg_valid(Cfg_valid),
        .Cfg_visible(Cfg_visible), .Cfg_front(Cfg_front),
        .Cfg_sync(Cfg_sync), .Cfg_back(Cfg_back),
`ifdef VGA_TIMING_POLARITY_EN
        .Cfg_sync_pol(Cfg_sync_pol),
`endif
        .Cfg_pending(Cfg_pending), .Cfg_err(Cfg_err), .Count(Count),
        .Phase(Phase), .Active(Active), .Sync(Sync), .Carry(Carry)
    );

    int n_cmp = 0, n_bad = 0;

    // Reference model state
    int m_cnt, mv, mf, ms, mb, pv, pf, ps, pb;
    bit mpol, ppol, m_pend, m_err;

    task automatic check(input string tag, input int obs, input int exp);
        n_cmp++;
        if (obs != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_cnt = 0; mv = 640; mf = 16; ms = 96; mb = 48; mpol = 0;
        m_pend = 0; m_err = 0;
    endtask

    // One clock: drive inputs, check current outputs, then advance the model.
    task automatic cycle(input bit rst, input bit en, input bit valid,
                         input int v, input int f, input int s, input int b, input bit p);
        int tot, ph;
        bit ok, wrap, pp;
        @(negedge Clk);
        Rst = rst; En = en; Cfg_valid = valid; Cfg_sync_pol = p;
        Cfg_visible = v[W-1:0]; Cfg_front = f[W-1:0];
        Cfg_sync = s[W-1:0];    Cfg_back = b[W-1:0];
        #1;
        tot = mv + mf + ms + mb;
        if (m_cnt < mv)                ph = 0;
        else if (m_cnt < mv + mf)      ph = 1;
        else if (m_cnt < mv + mf + ms) ph = 2;
        else                           ph = 3;
        check("count",   Count,       m_cnt);
        check("phase",   Phase,       ph);
        check("active",  Active,      ph == 0);
        check("sync",    Sync,        (ph == 2) ? mpol : !mpol);
        check("carry",   Carry,       en && (m_cnt == tot - 1));
        check("pending", Cfg_pending, m_pend);
        check("err",     Cfg_err,     m_err);
        @(posedge Clk);
        if (rst) begin
            model_reset();
        end else begin
            ok   = (v != 0) && (s != 0) && (v + f + s + b <= (1 << W));
            wrap = en && (m_cnt == tot - 1);
            m_err = valid && !ok;
            if (en) m_cnt = wrap ? 0 : m_cnt + 1;
            if (wrap && m_pend) begin
                mv = pv; mf = pf; ms = ps; mb = pb; mpol = ppol;
            end
`ifdef VGA_TIMING_POLARITY_EN
            pp = p;
`else
            pp = 1'b0;
`endif
            if (valid && ok) begin
                pv = v; pf = f; ps = s; pb = b; ppol = pp; m_pend = 1;
            end else if (wrap) begin
                m_pend = 0;
            end
        end
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) cycle(0, 1, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic cfg(input int v, input int f, input int s, input int b);
        cycle(0, 1, 1, v, f, s, b, 1'b1);
    endtask

    initial begin
        Rst = 1; En = 0; Cfg_valid = 0; Cfg_sync_pol = 0;
        Cfg_visible = '0; Cfg_front = '0; Cfg_sync = '0; Cfg_back = '0;
        repeat (2) @(posedge Clk);
        model_reset();

        // Reset state, then small mode taking effect after the 800-pixel default line
        cycle(1, 0, 0, 0, 0, 0, 0, 0);
        cfg(4, 1, 2, 1);
        run(800);
        run(16);

        // Enable toggling
        for (int i = 0; i < 16; i++) cycle(0, (i % 2) == 0, 0, 0, 0, 0, 0, 0);

        // Zero-length porches
        cfg(3, 0, 1, 0);
        run(14);

        // Rejected configs: V=0, S=0, total one past the limit
        cfg(0, 1, 1, 1);
        run(3);
        cfg(2, 1, 0, 1);
        run(2);
        cfg(4000, 32, 32, 33);
        run(6);

        // Last-writer-wins mid-line
        cfg(4, 1, 2, 1);
        cfg(6, 1, 1, 1);
        run(24);

        // Maximum legal total
        cfg(4000, 32, 32, 32);
        run(10);
        cfg(2, 1, 1, 1);
        run(4100);

        // Reset with a config pending, then a full default line
        cfg(5, 1, 1, 1);
        run(2);
        cycle(1, 1, 0, 0, 0, 0, 0, 0);
        run(805);

        // Randomized traffic
        cfg(5, 2, 2, 1);
        for (int i = 0; i < 4000; i++) begin
            int sel, v, f, s, b;
            sel = $urandom_range(0, 39);
            v = $urandom_range(1, 8); f = $urandom_range(0, 3);
            s = $urandom_range(0, 3); b = $urandom_range(0, 3);
            if (sel == 0)      begin v = 4000; f = 32; s = 32; b = 33; end
            else if (sel == 1) v = 0;
            cycle($urandom_range(0, 499) == 0, $urandom_range(0, 3) != 0,
                  $urandom_range(0, 9) == 0, v, f, s, b, 1'($urandom_range(0, 1)));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
